park_allocator: RTL and testbench

//   Entry/exit manager for the 8-spot parking lot, one stage upstream of decrypt.
//   - Entry: allocates the lowest free spot and issues token = spot ^ pattern.
//   - Exit: takes the park_number recovered by decrypt (token ^ pattern) and frees that spot.
//   - Owns the occupancy map, the gate timer and the pattern key; pattern is re-keyed

---
 rtl/park_allocator.sv | 145 ++++++++++++++
 tb/tb_park_allocator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_allocator.sv
// Entry/exit manager for the 8-spot lot: allocates the lowest free spot, issues
// pattern-masked tokens, frees spots on exit, runs the gate timer and re-keys when empty.
module park_allocator #(
   parameter int         GATE_CYCLES  = 4,
   parameter logic [2:0] PATTERN_SEED = 3'b101
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter,
   input  logic       exit,
   input  logic [2:0] park_number,
   output logic [2:0] pattern,
   output logic [2:0] token,
   output logic       token_valid,
   output logic       exit_ok,
   output logic       exit_err,
   output logic       reject,
   output logic       full,
   output logic [3:0] free_count,
   output logic       gate_open,
   output logic       busy
);

   localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   typedef enum logic {IDLE, GATE} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    occ_q, occ_d;
   logic [2:0]    pattern_q, pattern_d;
   logic [2:0]    token_q, token_d;
   logic          token_valid_q, token_valid_d;
   logic          exit_ok_q, exit_ok_d;
   logic          exit_err_q, exit_err_d;
   logic          reject_q, reject_d;
   logic          full_q, full_d;
   logic [3:0]    free_count_q, free_count_d;
   logic          gate_open_q, gate_open_d;
   logic          busy_q, busy_d;
   logic [2:0]    spot;
   logic [3:0]    occ_ones;

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      occ_d         = occ_q;
      pattern_d     = pattern_q;
      token_d       = token_q;
      token_valid_d = 1'b0;
      exit_ok_d     = 1'b0;
      exit_err_d    = 1'b0;
      reject_d      = 1'b0;
      spot          = 3'd0;
      occ_ones      = 4'd0;

      // Scan downwards so the last hit is the lowest free index.
      for (int i = 7; i >= 0; i--) begin
         if (!occ_q[i]) spot = 3'(i);
      end

      case (state_q)
         IDLE: begin
            if (exit) begin
               if (occ_q[park_number]) begin
                  occ_d[park_number] = 1'b0;
                  exit_ok_d          = 1'b1;
                  state_d            = GATE;
                  timer_d            = TW'(GATE_CYCLES - 1);
                  if (occ_d == 8'h00) pattern_d = {pattern_q[1:0], pattern_q[2] ^ pattern_q[1]};
               end else begin
                  exit_err_d = 1'b1;
               end
            end else if (enter) begin
               if (full_q) begin
                  reject_d = 1'b1;
               end else begin
                  occ_d[spot]   = 1'b1;
                  token_d       = spot ^ pattern_q;
                  token_valid_d = 1'b1;
                  state_d       = GATE;
                  timer_d       = TW'(GATE_CYCLES - 1);
               end
            end
         end
         GATE: begin
            if (timer_q == '0) state_d = IDLE;
            else               timer_d = timer_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      for (int i = 0; i < 8; i++) begin
         occ_ones = occ_ones + 4'(occ_d[i]);
      end
      free_count_d = 4'd8 - occ_ones;
      full_d       = (occ_d == 8'hFF);
      gate_open_d  = (state_d == GATE);
      busy_d       = (state_d == GATE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         occ_q         <= 8'h00;
         pattern_q     <= PATTERN_SEED;
         token_q       <= 3'b000;
         token_valid_q <= 1'b0;
         exit_ok_q     <= 1'b0;
         exit_err_q    <= 1'b0;
         reject_q      <= 1'b0;
         full_q        <= 1'b0;
         free_count_q  <= 4'd8;
         gate_open_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         occ_q         <= occ_d;
         pattern_q     <= pattern_d;
         token_q       <= token_d;
         token_valid_q <= token_valid_d;
         exit_ok_q     <= exit_ok_d;
         exit_err_q    <= exit_err_d;
         reject_q      <= reject_d;
         full_q        <= full_d;
         free_count_q  <= free_count_d;
         gate_open_q   <= gate_open_d;
         busy_q        <= busy_d;
      end
   end

   assign pattern     = pattern_q;
   assign token       = token_q;
   assign token_valid = token_valid_q;
   assign exit_ok     = exit_ok_q;
   assign exit_err    = exit_err_q;
   assign reject      = reject_q;
   assign full        = full_q;
   assign free_count  = free_count_q;
   assign gate_open   = gate_open_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_park_allocator.sv
// Self-checking bench for park_allocator: directed scenarios plus random traffic,
// all compared cycle by cycle against a spot-list/gate-countdown reference model.
module tb_park_allocator;

   localparam int GC = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enter;
   logic       exit;
   logic [2:0] park_number;
   logic [2:0] pattern;
   logic [2:0] token;
   logic       token_valid;
   logic       exit_ok;
   logic       exit_err;
   logic       reject;
   logic       full;
   logic [3:0] free_count;
   logic       gate_open;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   park_allocator #(.GATE_CYCLES(GC), .PATTERN_SEED(3'b101)) dut (
      .clk(clk), .reset(reset), .enter(enter), .exit(exit), .park_number(park_number),
      .pattern(pattern), .token(token), .token_valid(token_valid), .exit_ok(exit_ok),
      .exit_err(exit_err), .reject(reject), .full(full), .free_count(free_count),
      .gate_open(gate_open), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: list of occupied spots, key sequence index, gate countdown.
   logic [2:0] pat_seq [7] = '{3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001, 3'b010};
   bit         m_occ [8];
   int         m_pidx;
   logic [2:0] m_token;
   bit         m_tv, m_ok, m_err, m_rej;
   int         m_left;
   logic [16:0] exp_vec;
   logic [16:0] obs_vec;

   assign obs_vec = {pattern, token, token_valid, exit_ok, exit_err, reject,
                     full, free_count, gate_open, busy};

   function automatic int cars();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_occ[i]);
      return n;
   endfunction

   task automatic build_expected();
      int n = cars();
      exp_vec = {pat_seq[m_pidx], m_token, m_tv, m_ok, m_err, m_rej,
                 (n == 8), 4'(8 - n), (m_left > 0), (m_left > 0)};
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_occ[i] = 0;
      m_pidx = 0; m_token = 3'b000; m_left = 0;
      m_tv = 0; m_ok = 0; m_err = 0; m_rej = 0;
   endtask

   task automatic model_tick(input logic e, input logic x, input logic [2:0] pn);
      int s;
      m_tv = 0; m_ok = 0; m_err = 0; m_rej = 0;
      if (m_left > 0) begin
         m_left--;
      end else if (x) begin
         if (m_occ[pn]) begin
            m_occ[pn] = 0;
            m_ok      = 1;
            m_left    = GC;
            if (cars() == 0) m_pidx = (m_pidx + 1) % 7;
         end else begin
            m_err = 1;
         end
      end else if (e) begin
         if (cars() == 8) begin
            m_rej = 1;
         end else begin
            s = 0;
            while (m_occ[s]) s++;
            m_occ[s] = 1;
            m_token  = 3'(s) ^ pat_seq[m_pidx];
            m_tv     = 1;
            m_left   = GC;
         end
      end
   endtask

   task automatic step(input logic e, input logic x, input logic [2:0] pn);
      @(negedge clk);
      enter = e; exit = x; park_number = pn;
      model_tick(e, x, pn);
      @(posedge clk);
      #1;
      enter = 1'b0; exit = 1'b0;
      build_expected();
   endtask

   task automatic reset_step();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      build_expected();
   endtask

   task automatic drain(input string name);
      while (m_left > 0) begin
         step(1'b0, 1'b0, 3'(park_number + 3'd1));
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("[TB] FAIL %s_drain got %b expected %b", name, obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_reset();
      reset_step();
      n_cmp++;
      if (obs_vec !== 17'b101_000_0000_0_1000_0_0) begin
         n_bad++;
         $display("[TB] FAIL reset_values got %b expected %b", obs_vec, 17'b101_000_0000_0_1000_0_0);
      end
   endtask

   task automatic test_entry();
      step(1'b1, 1'b0, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || token !== 3'b101) begin
         n_bad++;
         $display("[TB] FAIL first_entry got %b expected %b", obs_vec, exp_vec);
      end
      drain("first_entry");
   endtask

   task automatic test_exit();
      step(1'b1, 1'b0, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || token !== 3'b100) begin
         n_bad++;
         $display("[TB] FAIL second_entry got %b expected %b", obs_vec, exp_vec);
      end
      drain("second_entry");
      step(1'b0, 1'b1, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || exit_ok !== 1'b1 || free_count !== 4'd7) begin
         n_bad++;
         $display("[TB] FAIL exit_spot0 got %b expected %b", obs_vec, exp_vec);
      end
      drain("exit_spot0");
   endtask

   task automatic test_exit_err();
      step(1'b0, 1'b1, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || exit_err !== 1'b1 || gate_open !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL exit_free_spot got %b expected %b", obs_vec, exp_vec);
      end
      step(1'b0, 1'b0, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
         n_bad++;
         $display("[TB] FAIL exit_err_after got %b expected %b", obs_vec, exp_vec);
      end
   endtask

   task automatic test_fill_reject();
      logic [2:0] held;
      while (cars() < 8) begin
         step(1'b1, 1'b0, 3'd0);
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("[TB] FAIL fill_entry got %b expected %b", obs_vec, exp_vec);
         end
         drain("fill");
      end
      n_cmp++;
      if (full !== 1'b1 || free_count !== 4'd0) begin
         n_bad++;
         $display("[TB] FAIL lot_full got full=%b free=%0d expected full=1 free=0", full, free_count);
      end
      held = m_token;
      step(1'b1, 1'b0, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || reject !== 1'b1 || token !== held) begin
         n_bad++;
         $display("[TB] FAIL ninth_reject got %b expected %b", obs_vec, exp_vec);
      end
   endtask

   task automatic test_rekey();
      reset_step();
      step(1'b1, 1'b0, 3'd0);
      drain("rekey_in");
      step(1'b0, 1'b1, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || pattern !== 3'b011) begin
         n_bad++;
         $display("[TB] FAIL rekey_pattern got %b expected %b", obs_vec, exp_vec);
      end
      drain("rekey_out");
      step(1'b1, 1'b0, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || token !== 3'b011) begin
         n_bad++;
         $display("[TB] FAIL rekey_token got %b expected %b", obs_vec, exp_vec);
      end
      drain("rekey_token");
   endtask

   task automatic test_back_to_back();
      reset_step();
      step(1'b1, 1'b0, 3'd0);
      drain("simul_in");
      step(1'b1, 1'b1, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || exit_ok !== 1'b1 || token_valid !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL enter_exit_together got %b expected %b", obs_vec, exp_vec);
      end
      step(1'b1, 1'b0, 3'd0);
      n_cmp++;
      if (obs_vec !== exp_vec || token_valid !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL enter_ignored_in_gate got %b expected %b", obs_vec, exp_vec);
      end
      drain("simul_out");
      step(1'b1, 1'b0, 3'd0);
      step(1'b0, 1'b0, 3'd0);
      reset_step();
      n_cmp++;
      if (obs_vec !== 17'b101_000_0000_0_1000_0_0) begin
         n_bad++;
         $display("[TB] FAIL reset_mid_gate got %b expected %b", obs_vec, 17'b101_000_0000_0_1000_0_0);
      end
   endtask

   task automatic test_random();
      logic e, x;
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(0, 99) < 55);
         x = ($urandom_range(0, 99) < 35);
         step(e, x, 3'($urandom_range(0, 7)));
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("[TB] FAIL random_cycle%0d got %b expected %b", i, obs_vec, exp_vec);
         end
      end
   endtask

   initial begin
      reset = 1'b1; enter = 1'b0; exit = 1'b0; park_number = 3'd0;
      model_reset();
      test_reset();
      test_entry();
      test_exit();
      test_exit_err();
      test_fill_reject();
      test_rekey();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
